l2_req_queue: RTL and testbench

Request queue between the instruction cache and the next-level cache. It captures each line-address request the instruction cache emits (26-bit line address plus 2-bit command), buffers up to DEPTH requests in order, and drains them to the next-level cache over a valid/ready handshake. It merges back-to-back duplicate reads, drops requests on overflow, and keeps request, merge and drop counts for the statistics module.

---
 rtl/l2_req_queue.sv | 124 ++++++++++++
 tb/tb_l2_req_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_queue.sv
// l2_req_queue: in-order request buffer between the instruction cache and the
// next-level cache. Merges back-to-back duplicate reads, drops requests that
// find the queue full, and keeps request/merge/drop statistics.
module l2_req_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 26,
    parameter int CNTW  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cmd_in,
    input  logic [AW-1:0]            add_in,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [1:0]               mem_cmd,
    output logic [AW-1:0]            mem_add,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic [CNTW-1:0]          reqs,
    output logic [CNTW-1:0]          merged,
    output logic [CNTW-1:0]          dropped
);

    localparam int              PW         = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [1:0]      CMD_NONE   = 2'b00;
    localparam logic [1:0]      CMD_READ   = 2'b01;

    logic [1:0]     cmd_mem  [DEPTH];
    logic [AW-1:0]  addr_mem [DEPTH];

    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  last_idx;
    logic [PW-1:0]  head_nx;
    logic [PW:0]    count_nx;
    logic           req;
    logic           do_merge;
    logic           do_deq;
    logic           do_enq;
    logic           do_drop;
    logic           load_incoming;

    assign full     = (count == FULL_COUNT);
    assign last_idx = tail - 1'b1;

    // Classify this cycle's request and dequeue, and work out the next occupancy and head.
    always_comb begin
        req           = (cmd_in != CMD_NONE);
        do_merge      = (cmd_in == CMD_READ) && (count != '0) &&
                        (cmd_mem[last_idx] == CMD_READ) && (addr_mem[last_idx] == add_in);
        do_deq        = mem_valid && mem_ready;
        do_enq        = req && !do_merge && (!full || do_deq);
        do_drop       = req && !do_merge && full && !do_deq;
        head_nx       = head;
        if (do_deq) begin
            head_nx = head + 1'b1;
        end
        count_nx      = count;
        if (do_enq) begin
            count_nx = count_nx + 1'b1;
        end
        if (do_deq) begin
            count_nx = count_nx - 1'b1;
        end
        // A lone entry after this edge that was just enqueued can only be the incoming request.
        load_incoming = do_enq && (count_nx == (PW + 1)'(1));
    end

    // Write accepted requests into the slot at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && do_enq) begin
            cmd_mem[tail]  <= cmd_in;
            addr_mem[tail] <= add_in;
        end
    end

    // Pointers, occupancy, sticky overflow, statistics and the registered head view.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            reqs      <= '0;
            merged    <= '0;
            dropped   <= '0;
            mem_valid <= 1'b0;
            mem_cmd   <= CMD_NONE;
            mem_add   <= '0;
        end else begin
            head  <= head_nx;
            count <= count_nx;
            if (do_enq) begin
                tail <= tail + 1'b1;
            end
            if (req) begin
                reqs <= reqs + 1'b1;
            end
            if (do_merge) begin
                merged <= merged + 1'b1;
            end
            if (do_drop) begin
                dropped  <= dropped + 1'b1;
                overflow <= 1'b1;
            end
            if (count_nx == '0) begin
                mem_valid <= 1'b0;
                mem_cmd   <= CMD_NONE;
                mem_add   <= '0;
            end else if (load_incoming) begin
                mem_valid <= 1'b1;
                mem_cmd   <= cmd_in;
                mem_add   <= add_in;
            end else begin
                mem_valid <= 1'b1;
                mem_cmd   <= cmd_mem[head_nx];
                mem_add   <= addr_mem[head_nx];
            end
        end
    end

endmodule

// File: tb/tb_l2_req_queue.sv
// tb_l2_req_queue: directed stimulus for l2_req_queue, with a queue-based
// reference model compared every cycle plus hand-computed literal checks.
module tb_l2_req_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 26;
    localparam int CNTW  = 32;

    localparam logic [1:0] NONE  = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;

    logic                    clk;
    logic                    rst;
    logic [1:0]              cmd_in;
    logic [AW-1:0]           add_in;
    logic                    mem_valid;
    logic                    mem_ready;
    logic [1:0]              mem_cmd;
    logic [AW-1:0]           mem_add;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    overflow;
    logic [CNTW-1:0]         reqs;
    logic [CNTW-1:0]         merged;
    logic [CNTW-1:0]         dropped;

    int checks = 0;
    int errors = 0;

    // Reference model state: the queue contents in order, plus statistics.
    logic [AW+1:0]   mq[$];
    logic [AW+1:0]   dlog[$];
    logic [CNTW-1:0] m_reqs;
    logic [CNTW-1:0] m_merged;
    logic [CNTW-1:0] m_dropped;
    logic            m_ovf;
    logic            model_on = 1'b0;

    l2_req_queue #(.DEPTH(DEPTH), .AW(AW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_in    (cmd_in),
        .add_in    (add_in),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_cmd   (mem_cmd),
        .mem_add   (mem_add),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .reqs      (reqs),
        .merged    (merged),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic [AW-1:0] a, input logic r);
        cmd_in    = c;
        add_in    = a;
        mem_ready = r;
        @(negedge clk);
    endtask

    task automatic drainAll(input int maxCycles);
        for (int i = 0; i < maxCycles && mem_valid; i++) begin
            applyStimulus(NONE, '0, 1'b1);
        end
        if (mem_valid) begin
            checkOutput("drain_timeout", 64'(mem_valid), 64'd0);
        end
    endtask

    task automatic checkLogAddr(input string name, input int idx, input logic [1:0] c, input logic [AW-1:0] a);
        logic [AW+1:0] e;
        if (idx < dlog.size()) begin
            e = dlog[idx];
            checkOutput(name, 64'(e), 64'({c, a}));
        end else begin
            checkOutput(name, 64'(dlog.size()), 64'(idx + 1));
        end
    endtask

    // Advance the model at each edge from the rules: merge against the newest entry, pop, then push.
    always @(posedge clk) begin
        logic deq;
        logic mrg;
        logic [AW+1:0] e;
        if (rst) begin
            mq.delete();
            m_reqs    = '0;
            m_merged  = '0;
            m_dropped = '0;
            m_ovf     = 1'b0;
            model_on  = 1'b1;
        end else if (model_on) begin
            if (mem_valid && mem_ready) begin
                dlog.push_back({mem_cmd, mem_add});
            end
            deq = (mq.size() > 0) && mem_ready;
            mrg = 1'b0;
            e   = '0;
            if (cmd_in != NONE) begin
                m_reqs = m_reqs + 1;
                if (cmd_in == READ && mq.size() > 0) begin
                    e   = mq[$];
                    mrg = (e == {READ, add_in});
                end
            end
            if (deq) begin
                void'(mq.pop_front());
            end
            if (cmd_in != NONE) begin
                if (mrg) begin
                    m_merged = m_merged + 1;
                end else if (mq.size() < DEPTH) begin
                    mq.push_back({cmd_in, add_in});
                end else begin
                    m_dropped = m_dropped + 1;
                    m_ovf     = 1'b1;
                end
            end
        end
    end

    // Compare every DUT output against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        logic [AW+1:0] h;
        if (model_on) begin
            h = (mq.size() > 0) ? mq[0] : '0;
            checkOutput("mem_valid", 64'(mem_valid), 64'(mq.size() != 0));
            checkOutput("mem_cmd",   64'(mem_cmd),   64'(h[AW+1:AW]));
            checkOutput("mem_add",   64'(mem_add),   64'(h[AW-1:0]));
            checkOutput("count",     64'(count),     64'(mq.size()));
            checkOutput("full",      64'(full),      64'(mq.size() == DEPTH));
            checkOutput("overflow",  64'(overflow),  64'(m_ovf));
            checkOutput("reqs",      64'(reqs),      64'(m_reqs));
            checkOutput("merged",    64'(merged),    64'(m_merged));
            checkOutput("dropped",   64'(dropped),   64'(m_dropped));
        end
    end

    initial begin
        rst       = 1'b1;
        cmd_in    = NONE;
        add_in    = '0;
        mem_ready = 1'b0;

        // Reset and idle
        applyStimulus(NONE, '0, 1'b0);
        applyStimulus(NONE, '0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(NONE, '0, 1'b1);
        checkOutput("idle_count", 64'(count), 64'd0);
        checkOutput("idle_valid", 64'(mem_valid), 64'd0);

        // Single request stalled for three cycles
        applyStimulus(READ, 26'h0ABCDEF, 1'b0);
        checkOutput("single_valid", 64'(mem_valid), 64'd1);
        checkOutput("single_add", 64'(mem_add), 64'h0ABCDEF);
        applyStimulus(NONE, '0, 1'b0);
        applyStimulus(NONE, '0, 1'b0);
        checkOutput("single_stall_add", 64'(mem_add), 64'h0ABCDEF);
        applyStimulus(NONE, '0, 1'b1);
        checkOutput("single_done_count", 64'(count), 64'd0);
        checkOutput("single_done_valid", 64'(mem_valid), 64'd0);

        // Merge of back-to-back identical reads
        applyStimulus(READ,  26'h100, 1'b0);
        applyStimulus(READ,  26'h100, 1'b0);
        applyStimulus(WRITE, 26'h100, 1'b0);
        applyStimulus(READ,  26'h100, 1'b0);
        checkOutput("merge_count", 64'(count), 64'd3);
        checkOutput("merge_reqs", 64'(reqs), 64'd5);
        checkOutput("merge_merged", 64'(merged), 64'd1);
        dlog.delete();
        drainAll(20);
        checkOutput("merge_drain_n", 64'(dlog.size()), 64'd3);
        checkLogAddr("merge_drain0", 0, READ,  26'h100);
        checkLogAddr("merge_drain1", 1, WRITE, 26'h100);
        checkLogAddr("merge_drain2", 2, READ,  26'h100);

        // Overflow: ten distinct reads into eight slots
        for (int i = 0; i < 10; i++) applyStimulus(READ, AW'(i), 1'b0);
        checkOutput("ovf_full", 64'(full), 64'd1);
        checkOutput("ovf_count", 64'(count), 64'd8);
        checkOutput("ovf_dropped", 64'(dropped), 64'd2);
        checkOutput("ovf_flag", 64'(overflow), 64'd1);
        dlog.delete();
        drainAll(20);
        checkOutput("ovf_drain_n", 64'(dlog.size()), 64'd8);
        for (int i = 0; i < 8; i++) checkLogAddr("ovf_drain", i, READ, AW'(i));

        // Full queue with a simultaneous dequeue accepts the new request
        for (int i = 0; i < 8; i++) applyStimulus(READ, AW'(16 + i), 1'b0);
        checkOutput("fulldq_full", 64'(full), 64'd1);
        dlog.delete();
        applyStimulus(READ, 26'h3FF, 1'b1);
        checkOutput("fulldq_count", 64'(count), 64'd8);
        checkOutput("fulldq_dropped", 64'(dropped), 64'd2);
        drainAll(20);
        checkOutput("fulldq_drain_n", 64'(dlog.size()), 64'd9);
        checkLogAddr("fulldq_first", 0, READ, 26'h10);
        checkLogAddr("fulldq_last", 8, READ, 26'h3FF);

        // Merge against an entry that leaves the queue in the same cycle
        applyStimulus(READ, 26'h40, 1'b0);
        applyStimulus(READ, 26'h40, 1'b1);
        checkOutput("mrgdq_merged", 64'(merged), 64'd2);
        checkOutput("mrgdq_count", 64'(count), 64'd0);

        // Sustained traffic across the pointer wrap
        dlog.delete();
        for (int i = 0; i < 20; i++) applyStimulus((i % 2) ? WRITE : READ, AW'(512 + i), 1'b1);
        drainAll(20);
        checkOutput("sust_drain_n", 64'(dlog.size()), 64'd20);
        for (int i = 0; i < 20; i++) checkLogAddr("sust_drain", i, (i % 2) ? WRITE : READ, AW'(512 + i));
        checkOutput("sust_reqs", 64'(reqs), 64'd46);

        // Reset while stalled with five entries queued
        for (int i = 0; i < 5; i++) applyStimulus(READ, AW'(768 + i), 1'b0);
        checkOutput("rstmid_pre_count", 64'(count), 64'd5);
        rst = 1'b1;
        applyStimulus(READ, 26'h55, 1'b0);
        rst = 1'b0;
        checkOutput("rstmid_valid", 64'(mem_valid), 64'd0);
        checkOutput("rstmid_count", 64'(count), 64'd0);
        checkOutput("rstmid_reqs", 64'(reqs), 64'd0);
        checkOutput("rstmid_ovf", 64'(overflow), 64'd0);
        applyStimulus(READ, 26'h77, 1'b0);
        checkOutput("rstmid_next_valid", 64'(mem_valid), 64'd1);
        checkOutput("rstmid_next_add", 64'(mem_add), 64'h77);
        applyStimulus(NONE, '0, 1'b1);
        checkOutput("rstmid_next_done", 64'(mem_valid), 64'd0);
        applyStimulus(NONE, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a run that never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
